// File: rtl/gpio_ctrl_pkg.sv
// Shared constants and types for the gpio_ctrl register block.
// Register indices, bus FSM states and the post-reset edge arming delay.
package gpio_ctrl_pkg;

  localparam logic [2:0] A_DOUT = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_DIN  = 3'd2;
  localparam logic [2:0] A_IEN  = 3'd3;
  localparam logic [2:0] A_RISE = 3'd4;
  localparam logic [2:0] A_FALL = 3'd5;
  localparam logic [2:0] A_STAT = 3'd6;
  localparam logic [2:0] A_CFG  = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } bus_state_e;

  localparam logic [2:0] ARM_CYCLES = 3'd4;

endpackage

// File: rtl/gpio_in_filter.sv
// Per-pin input conditioning: 2-flop synchroniser, 2-deep history and an
// optional deglitch filter that only accepts a level seen on three consecutive samples.
module gpio_in_filter
  import gpio_ctrl_pkg::*;
#(
  parameter int NPIN = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            filt_en,
  input  logic [NPIN-1:0] pin,
  output logic [NPIN-1:0] din
);

  logic [NPIN-1:0] s1_r;
  logic [NPIN-1:0] s2_r;
  logic [NPIN-1:0] h1_r;
  logic [NPIN-1:0] h2_r;
  logic [NPIN-1:0] din_r;
  logic [NPIN-1:0] stable_s;
  logic [NPIN-1:0] din_next_s;

  // Next filtered value: pass-through, or update only on pins stable for three samples
  always_comb begin
    stable_s   = ~(s2_r ^ h1_r) & ~(s2_r ^ h2_r);
    din_next_s = s2_r;
    if (filt_en) begin
      din_next_s = (s2_r & stable_s) | (din_r & ~stable_s);
    end else begin
      din_next_s = s2_r;
    end
  end

  // Synchroniser, history and filtered-output flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r  <= {NPIN{1'b0}};
      s2_r  <= {NPIN{1'b0}};
      h1_r  <= {NPIN{1'b0}};
      h2_r  <= {NPIN{1'b0}};
      din_r <= {NPIN{1'b0}};
    end else begin
      s1_r  <= pin;
      s2_r  <= s1_r;
      h1_r  <= s2_r;
      h2_r  <= h1_r;
      din_r <= din_next_s;
    end
  end

  assign din = din_r;

endmodule

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: req/ack register port, pad output/enable
// registers, conditioned inputs with edge detection and a level interrupt.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int NPIN = 7,
  parameter int AW   = 3,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bus_req,
  input  logic            bus_we,
  input  logic [AW-1:0]   bus_addr,
  input  logic [DW-1:0]   bus_wdata,
  output logic [DW-1:0]   bus_rdata,
  output logic            bus_ack,
  input  logic [NPIN-1:0] pin,
  output logic [NPIN-1:0] pout,
  output logic [NPIN-1:0] p_oe,
  output logic            irq
);

  bus_state_e      state_r;
  bus_state_e      state_next_s;
  logic            we_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic            ack_r;
  logic [DW-1:0]   rdata_r;
  logic [NPIN-1:0] dout_r;
  logic [NPIN-1:0] dir_r;
  logic [NPIN-1:0] ien_r;
  logic [NPIN-1:0] rise_r;
  logic [NPIN-1:0] fall_r;
  logic [NPIN-1:0] stat_r;
  logic            cfg_r;
  logic            irq_r;
  logic [NPIN-1:0] din_s;
  logic [NPIN-1:0] din_d_r;
  logic [2:0]      arm_cnt_r;
  logic            wr_s;
  logic [NPIN-1:0] edge_s;
  logic [NPIN-1:0] w1c_s;
  logic [NPIN-1:0] stat_next_s;
  logic [DW-1:0]   rd_s;

  gpio_in_filter #(.NPIN(NPIN)) u_in_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .filt_en (cfg_r),
    .pin     (pin),
    .din     (din_s)
  );

  // Bus FSM next state, edge/W1C status update and read-data mux
  always_comb begin
    state_next_s = S_IDLE;
    wr_s         = (state_r == S_ACK) && we_r;
    edge_s       = {NPIN{1'b0}};
    w1c_s        = {NPIN{1'b0}};
    rd_s         = {DW{1'b0}};

    case (state_r)
      S_IDLE: begin
        if (bus_req) begin
          state_next_s = S_ACK;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ACK:   state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase

    // Edges are masked until the arm counter saturates, hiding pins that were high through reset.
    if (arm_cnt_r == ARM_CYCLES) begin
      edge_s = (din_s & ~din_d_r & rise_r) | (~din_s & din_d_r & fall_r);
    end else begin
      edge_s = {NPIN{1'b0}};
    end

    if (wr_s && (addr_r == A_STAT)) begin
      w1c_s = wdata_r[NPIN-1:0];
    end else begin
      w1c_s = {NPIN{1'b0}};
    end
    stat_next_s = (stat_r & ~w1c_s) | edge_s;

    case (addr_r)
      A_DOUT:  rd_s[NPIN-1:0] = dout_r;
      A_DIR:   rd_s[NPIN-1:0] = dir_r;
      A_DIN:   rd_s[NPIN-1:0] = din_s;
      A_IEN:   rd_s[NPIN-1:0] = ien_r;
      A_RISE:  rd_s[NPIN-1:0] = rise_r;
      A_FALL:  rd_s[NPIN-1:0] = fall_r;
      A_STAT:  rd_s[NPIN-1:0] = stat_r;
      A_CFG:   rd_s[0]        = cfg_r;
      default: rd_s           = {DW{1'b0}};
    endcase
  end

  // Bus handshake, register file, status, interrupt and arming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      we_r      <= 1'b0;
      addr_r    <= {AW{1'b0}};
      wdata_r   <= {DW{1'b0}};
      ack_r     <= 1'b0;
      rdata_r   <= {DW{1'b0}};
      dout_r    <= {NPIN{1'b0}};
      dir_r     <= {NPIN{1'b0}};
      ien_r     <= {NPIN{1'b0}};
      rise_r    <= {NPIN{1'b0}};
      fall_r    <= {NPIN{1'b0}};
      stat_r    <= {NPIN{1'b0}};
      cfg_r     <= 1'b0;
      irq_r     <= 1'b0;
      din_d_r   <= {NPIN{1'b0}};
      arm_cnt_r <= 3'd0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == S_IDLE) && bus_req) begin
        we_r    <= bus_we;
        addr_r  <= bus_addr;
        wdata_r <= bus_wdata;
      end
      ack_r   <= (state_r == S_ACK);
      rdata_r <= (state_r == S_ACK) ? rd_s : {DW{1'b0}};
      if (wr_s) begin
        case (addr_r)
          A_DOUT:  dout_r <= wdata_r[NPIN-1:0];
          A_DIR:   dir_r  <= wdata_r[NPIN-1:0];
          A_IEN:   ien_r  <= wdata_r[NPIN-1:0];
          A_RISE:  rise_r <= wdata_r[NPIN-1:0];
          A_FALL:  fall_r <= wdata_r[NPIN-1:0];
          A_CFG:   cfg_r  <= wdata_r[0];
          default: begin end
        endcase
      end
      stat_r  <= stat_next_s;
      irq_r   <= |(stat_next_s & ien_r);
      din_d_r <= din_s;
      if (arm_cnt_r != ARM_CYCLES) begin
        arm_cnt_r <= arm_cnt_r + 3'd1;
      end
    end
  end

  generate
    if (DW > NPIN) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^wdata_r[DW-1:NPIN];
    end
  endgenerate

  assign bus_ack   = ack_r;
  assign bus_rdata = rdata_r;
  assign pout      = dout_r;
  assign p_oe      = dir_r;
  assign irq       = irq_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl: register port, input filter,
// edge/STAT/irq behaviour, arming and reset during a transaction.
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       bus_req;
  logic       bus_we;
  logic [2:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic [6:0] pin;
  logic [6:0] pout;
  logic [6:0] p_oe;
  logic       irq;

  int vectors;
  int miscompares;
  logic [7:0] d;
  int lat;

  gpio_ctrl #(.NPIN(7), .AW(3), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .pin       (pin),
    .pout      (pout),
    .p_oe      (p_oe),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; lat = ticks until ack (0 = timed out, rd left as x).
  task automatic bus_xfer(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output int lt);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    lt = 0; rd = 8'hxx;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus_ack === 1'b1) begin
        lt = i; rd = bus_rdata;
        break;
      end
    end
    bus_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pin = 7'h7F;
    repeat (3) tick();
    vectors++; if (bus_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack got=%b want=0", bus_ack); end
    vectors++; if (bus_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata got=%h want=00", bus_rdata); end
    vectors++; if (pout !== 7'h00) begin miscompares++; $display("FAIL rst_pout got=%h want=00", pout); end
    vectors++; if (p_oe !== 7'h00) begin miscompares++; $display("FAIL rst_poe got=%h want=00", p_oe); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq got=%b want=0", irq); end
    rst_n = 1'b1;
    bus_xfer(1'b1, A_RISE, 8'h7F, d, lat);
    bus_xfer(1'b1, A_IEN, 8'h7F, d, lat);
    repeat (6) tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL arm_irq got=%b want=0", irq); end
    bus_xfer(1'b0, A_STAT, 8'h00, d, lat);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL arm_stat got=%h want=00", d); end
    bus_xfer(1'b0, A_DIN, 8'h00, d, lat);
    vectors++; if (d !== 8'h7F) begin miscompares++; $display("FAIL arm_din got=%h want=7f", d); end
    bus_xfer(1'b1, A_RISE, 8'h00, d, lat);
    bus_xfer(1'b1, A_IEN, 8'h00, d, lat);
    pin = 7'h00;
    repeat (6) tick();
  endtask

  task automatic test_dir_dout();
    bus_xfer(1'b1, A_DIR, 8'h0F, d, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL dir_lat got=%0d want=2", lat); end
    vectors++; if (p_oe !== 7'h0F) begin miscompares++; $display("FAIL dir_poe got=%h want=0f", p_oe); end
    bus_xfer(1'b1, A_DOUT, 8'h55, d, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL dout_lat got=%0d want=2", lat); end
    vectors++; if (pout !== 7'h55) begin miscompares++; $display("FAIL dout_pout got=%h want=55", pout); end
    tick();
    vectors++; if (bus_ack !== 1'b0) begin miscompares++; $display("FAIL ack_pulse got=%b want=0", bus_ack); end
    vectors++; if (bus_rdata !== 8'h00) begin miscompares++; $display("FAIL rdata_idle got=%h want=00", bus_rdata); end
    bus_xfer(1'b0, A_DIR, 8'h00, d, lat);
    vectors++; if (d !== 8'h0F) begin miscompares++; $display("FAIL rd_dir got=%h want=0f", d); end
    bus_xfer(1'b0, A_DOUT, 8'h00, d, lat);
    vectors++; if (d !== 8'h55) begin miscompares++; $display("FAIL rd_dout got=%h want=55", d); end
  endtask

  task automatic test_regmap();
    bus_xfer(1'b1, A_DOUT, 8'hFF, d, lat);
    vectors++; if (pout !== 7'h7F) begin miscompares++; $display("FAIL dout_ff got=%h want=7f", pout); end
    bus_xfer(1'b0, A_DOUT, 8'h00, d, lat);
    vectors++; if (d !== 8'h7F) begin miscompares++; $display("FAIL rd_dout_ff got=%h want=7f", d); end
    bus_xfer(1'b1, A_CFG, 8'hFF, d, lat);
    bus_xfer(1'b0, A_CFG, 8'h00, d, lat);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL rd_cfg got=%h want=01", d); end
    bus_xfer(1'b1, A_CFG, 8'h00, d, lat);
    bus_xfer(1'b1, A_DIN, 8'h55, d, lat);
    bus_xfer(1'b0, A_DIN, 8'h00, d, lat);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL din_ro got=%h want=00", d); end
  endtask

  task automatic test_filter_off();
    bus_xfer(1'b1, A_RISE, 8'h08, d, lat);
    bus_xfer(1'b1, A_IEN, 8'h08, d, lat);
    tick();
    pin = 7'h08;
    tick(); tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL off_irq_n1 got=%b want=0", irq); end
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_DIN; bus_wdata = 8'h00;
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL off_irq_n2 got=%b want=0", irq); end
    tick();
    bus_req = 1'b0;
    vectors++; if (bus_ack !== 1'b1) begin miscompares++; $display("FAIL off_ack got=%b want=1", bus_ack); end
    vectors++; if (bus_rdata !== 8'h08) begin miscompares++; $display("FAIL off_din got=%h want=08", bus_rdata); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL off_irq_n3 got=%b want=1", irq); end
    bus_xfer(1'b0, A_STAT, 8'h00, d, lat);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL off_stat got=%h want=08", d); end
    bus_xfer(1'b1, A_STAT, 8'h08, d, lat);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL w1c_irq got=%b want=0", irq); end
    bus_xfer(1'b0, A_STAT, 8'h00, d, lat);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL w1c_stat got=%h want=00", d); end
  endtask

  task automatic test_filter_on();
    bus_xfer(1'b1, A_CFG, 8'h01, d, lat);
    bus_xfer(1'b1, A_RISE, 8'h04, d, lat);
    bus_xfer(1'b1, A_IEN, 8'h04, d, lat);
    tick();
    pin = 7'h0C;
    tick(); tick();
    pin = 7'h08;
    repeat (8) tick();
    bus_xfer(1'b0, A_DIN, 8'h00, d, lat);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL glitch_din got=%h want=08", d); end
    bus_xfer(1'b0, A_STAT, 8'h00, d, lat);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL glitch_stat got=%h want=00", d); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL glitch_irq got=%b want=0", irq); end
    tick();
    pin = 7'h0C;
    tick(); tick(); tick();
    pin = 7'h08;
    tick();
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_DIN; bus_wdata = 8'h00;
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL on_irq_n4 got=%b want=0", irq); end
    tick();
    bus_req = 1'b0;
    vectors++; if (bus_rdata !== 8'h0C) begin miscompares++; $display("FAIL on_din got=%h want=0c", bus_rdata); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL on_irq_n5 got=%b want=1", irq); end
    bus_xfer(1'b0, A_STAT, 8'h00, d, lat);
    vectors++; if (d !== 8'h04) begin miscompares++; $display("FAIL on_stat got=%h want=04", d); end
    bus_xfer(1'b1, A_STAT, 8'h04, d, lat);
    bus_xfer(1'b1, A_IEN, 8'h00, d, lat);
    bus_xfer(1'b1, A_RISE, 8'h00, d, lat);
    repeat (6) tick();
  endtask

  task automatic test_w1c_vs_fall();
    bus_xfer(1'b1, A_CFG, 8'h00, d, lat);
    bus_xfer(1'b1, A_FALL, 8'h01, d, lat);
    pin = 7'h09;
    repeat (6) tick();
    bus_xfer(1'b0, A_STAT, 8'h00, d, lat);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL pre_stat got=%h want=00", d); end
    tick();
    pin = 7'h08;
    tick(); tick();
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = A_STAT; bus_wdata = 8'h01;
    tick();
    tick();
    bus_req = 1'b0;
    vectors++; if (bus_ack !== 1'b1) begin miscompares++; $display("FAIL race_ack got=%b want=1", bus_ack); end
    bus_xfer(1'b0, A_STAT, 8'h00, d, lat);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL race_stat got=%h want=01", d); end
    bus_xfer(1'b1, A_STAT, 8'h01, d, lat);
    bus_xfer(1'b0, A_STAT, 8'h00, d, lat);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL race_clr got=%h want=00", d); end
  endtask

  task automatic test_reset_midtx();
    rst_n = 1'b0; bus_req = 1'b1; bus_we = 1'b1; bus_addr = A_DOUT; bus_wdata = 8'h33;
    tick();
    rst_n = 1'b1; bus_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (bus_ack !== 1'b0) begin miscompares++; $display("FAIL midtx_ack%0d got=%b want=0", i, bus_ack); end
    end
    vectors++; if (pout !== 7'h00) begin miscompares++; $display("FAIL midtx_pout got=%h want=00", pout); end
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = A_DIR; bus_wdata = 8'h5A;
    tick();
    rst_n = 1'b0; bus_req = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if (bus_ack !== 1'b0) begin miscompares++; $display("FAIL late_ack got=%b want=0", bus_ack); end
    vectors++; if (p_oe !== 7'h00) begin miscompares++; $display("FAIL late_poe got=%h want=00", p_oe); end
    tick();
    vectors++; if (bus_ack !== 1'b0) begin miscompares++; $display("FAIL late_ack2 got=%b want=0", bus_ack); end
    bus_xfer(1'b0, A_DIR, 8'h00, d, lat);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL late_dir got=%h want=00", d); end
    bus_xfer(1'b0, A_DOUT, 8'h00, d, lat);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL midtx_dout got=%h want=00", d); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 3'd0; bus_wdata = 8'h00; pin = 7'h00;
    test_reset();
    test_dir_dout();
    test_regmap();
    test_filter_off();
    test_filter_on();
    test_w1c_vs_fall();
    test_reset_midtx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
